// File: rtl/adc_spi_read_access_if.sv
// Bus between the ADC read controller, the acquisition control logic and the
// serial ADC pins. The slave side is the controller; the master side is
// whatever triggers it and supplies serial data.
interface adc_spi_read_access_if #(
    parameter int DATA_BITS = 16
);
    logic                 TR;
    logic                 AD_SDI;
    logic                 AD_CS;
    logic                 AD_SCLK;
    logic [DATA_BITS-1:0] DATA;
    logic                 VALID;
    logic                 BUSY;

    modport master (
        output TR,
        output AD_SDI,
        input  AD_CS,
        input  AD_SCLK,
        input  DATA,
        input  VALID,
        input  BUSY
    );

    modport slave (
        input  TR,
        input  AD_SDI,
        output AD_CS,
        output AD_SCLK,
        output DATA,
        output VALID,
        output BUSY
    );
endinterface

// File: rtl/adc_spi_read_access.sv
// SPI read controller for an ADS8325-style 16-bit serial ADC. A trigger starts
// one transfer: chip-select low, LEAD_BITS + DATA_BITS SCLK periods, sample
// captured MSB first, parallel result with a one-cycle VALID strobe.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | AD_CS high, waiting for TR
// SETUP | AD_CS low, CS-to-SCLK setup delay of CLK_DIV cycles
// HIGH  | AD_SCLK high for CLK_DIV cycles (sample taken on entry)
// LOW   | AD_SCLK low for CLK_DIV cycles between bits
// GAP   | AD_CS high for CS_HIGH cycles before the next trigger may start
module adc_spi_read_access #(
    parameter int CLK_DIV   = 4,
    parameter int LEAD_BITS = 6,
    parameter int DATA_BITS = 16,
    parameter int CS_HIGH   = 8
) (
    input  logic                  CLK,
    input  logic                  RESET,
    adc_spi_read_access_if.slave  bus
);

    localparam int N      = LEAD_BITS + DATA_BITS;
    localparam int CNT_MAX = (CLK_DIV > CS_HIGH) ? CLK_DIV : CS_HIGH;
    localparam int CW     = $clog2(CNT_MAX + 1);
    localparam int BW     = $clog2(N + 1);

    localparam logic [CW-1:0] DIV_LOAD = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] GAP_LOAD = CW'(CS_HIGH - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(N - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_HIGH,
        S_LOW,
        S_GAP
    } state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [BW-1:0]        bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 cs_q, cs_d;
    logic                 sclk_q, sclk_d;
    logic                 valid_q, valid_d;
    logic                 busy_q, busy_d;

    // Shift register with the current AD_SDI inserted at the LSB. Lead bits
    // are shifted through too; they fall off the top before the transfer ends.
    logic [DATA_BITS-1:0] shift_in;
    assign shift_in = (shift_q << 1) | DATA_BITS'(bus.AD_SDI);

    // Next-state and next-output logic for the transfer sequencer.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        data_d  = data_q;
        cs_d    = cs_q;
        sclk_d  = sclk_q;
        valid_d = 1'b0;
        busy_d  = busy_q;

        case (state_q)
            S_IDLE: begin
                // BUSY is released here rather than in GAP so that it covers
                // the full CS-high interval, including the cycle in which the
                // next trigger is sampled.
                busy_d = 1'b0;
                if (bus.TR) begin
                    cs_d    = 1'b0;
                    busy_d  = 1'b1;
                    cnt_d   = DIV_LOAD;
                    bit_d   = '0;
                    state_d = S_SETUP;
                end
            end

            S_SETUP: begin
                if (cnt_q == '0) begin
                    sclk_d  = 1'b1;
                    shift_d = shift_in;
                    cnt_d   = DIV_LOAD;
                    state_d = S_HIGH;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end

            S_HIGH: begin
                if (cnt_q == '0) begin
                    sclk_d = 1'b0;
                    if (bit_q == LAST_BIT) begin
                        cs_d    = 1'b1;
                        data_d  = shift_q;
                        valid_d = 1'b1;
                        cnt_d   = GAP_LOAD;
                        state_d = S_GAP;
                    end else begin
                        cnt_d   = DIV_LOAD;
                        state_d = S_LOW;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end

            S_LOW: begin
                if (cnt_q == '0) begin
                    sclk_d  = 1'b1;
                    bit_d   = bit_q + BW'(1);
                    shift_d = shift_in;
                    cnt_d   = DIV_LOAD;
                    state_d = S_HIGH;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end

            S_GAP: begin
                if (cnt_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end

            default: begin
                state_d = S_IDLE;
                cs_d    = 1'b1;
                sclk_d  = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State, counters and all outputs registered; reset forces the idle bus.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            cs_q    <= 1'b1;
            sclk_q  <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            cs_q    <= cs_d;
            sclk_q  <= sclk_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.AD_CS   = cs_q;
    assign bus.AD_SCLK = sclk_q;
    assign bus.DATA    = data_q;
    assign bus.VALID   = valid_q;
    assign bus.BUSY    = busy_q;

endmodule

// File: tb/tb_adc_spi_read_access.sv
// Bench for adc_spi_read_access: default-parameter instance with a scoreboard
// and SCLK phase monitor, plus a fast instance (CLK_DIV=1, no lead bits).
module tb_adc_spi_read_access;

    localparam int CLK_DIV   = 4;
    localparam int LEAD_BITS = 6;
    localparam int DATA_BITS = 16;
    localparam int CS_HIGH   = 8;
    localparam int N         = LEAD_BITS + DATA_BITS;     // 22
    localparam int LAT       = 2 * CLK_DIV * N;           // 176
    localparam int PERIOD    = LAT + CS_HIGH + 1;         // 185
    localparam int N1        = 16;

    logic CLK = 1'b0;
    logic RESET = 1'b0;
    int   cyc = 0;

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    adc_spi_read_access_if #(.DATA_BITS(DATA_BITS)) bus0 ();
    adc_spi_read_access_if #(.DATA_BITS(DATA_BITS)) bus1 ();

    adc_spi_read_access #(
        .CLK_DIV(CLK_DIV), .LEAD_BITS(LEAD_BITS), .DATA_BITS(DATA_BITS), .CS_HIGH(CS_HIGH)
    ) dut0 (
        .CLK(CLK), .RESET(RESET), .bus(bus0.slave)
    );

    adc_spi_read_access #(
        .CLK_DIV(1), .LEAD_BITS(0), .DATA_BITS(DATA_BITS), .CS_HIGH(CS_HIGH)
    ) dut1 (
        .CLK(CLK), .RESET(RESET), .bus(bus1.slave)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        logic [15:0] data;
        int          at;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] model_q[$];
    logic [31:0] model1_q[$];

    int   valid_cnt = 0;
    int   last_valid_cyc = 0;
    int   rise_cnt = 0;
    int   run_len = 0;
    int   cs_low_len = 0;
    int   cs_high_len = 0;
    int   last_cs_low = 0;
    int   last_cs_gap = 0;
    logic prev_cs = 1'b1;
    logic prev_sclk = 1'b0;
    bit   phase_en = 1'b0;

    // ADC model for instance 0: first bit on CS fall, next bit on each SCLK fall.
    initial begin : adc_model0
        logic [31:0] word;
        int idx;
        bus0.AD_SDI = 1'b0;
        forever begin
            @(negedge bus0.AD_CS);
            word = 32'h0;
            if (model_q.size() > 0) word = model_q.pop_front();
            idx = N - 1;
            bus0.AD_SDI = word[idx];
            forever begin
                @(negedge bus0.AD_SCLK or posedge bus0.AD_CS);
                if (bus0.AD_CS) break;
                idx--;
                if (idx >= 0) bus0.AD_SDI = word[idx];
            end
        end
    end

    // ADC model for instance 1.
    initial begin : adc_model1
        logic [31:0] word;
        int idx;
        bus1.AD_SDI = 1'b0;
        forever begin
            @(negedge bus1.AD_CS);
            word = 32'h0;
            if (model1_q.size() > 0) word = model1_q.pop_front();
            idx = N1 - 1;
            bus1.AD_SDI = word[idx];
            forever begin
                @(negedge bus1.AD_SCLK or posedge bus1.AD_CS);
                if (bus1.AD_CS) break;
                idx--;
                if (idx >= 0) bus1.AD_SDI = word[idx];
            end
        end
    end

    // Scoreboard consumer and SCLK/CS phase monitor for instance 0.
    initial begin : monitor0
        exp_t e;
        forever begin
            @(negedge CLK);
            if (bus0.VALID === 1'b1) begin
                valid_cnt++;
                last_valid_cyc = cyc;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_valid: DATA 0x%0h at cycle %0d, none expected", bus0.DATA, cyc);
                end else begin
                    e = exp_q.pop_front();
                    check("data", 32'(bus0.DATA), 32'(e.data));
                    check("valid_cycle", cyc, e.at);
                end
            end
            if (phase_en) begin
                if (bus0.AD_CS !== prev_cs) begin
                    if (bus0.AD_CS === 1'b0) begin
                        last_cs_gap = cs_high_len;
                        cs_low_len  = 1;
                        run_len     = 1;
                        rise_cnt    = 0;
                    end else begin
                        check("cs_rise_on_last_sclk_fall", 32'({prev_sclk, bus0.AD_SCLK}), 32'h2);
                        check("sclk_last_high_width", run_len, CLK_DIV);
                        last_cs_low = cs_low_len;
                        cs_high_len = 1;
                    end
                end else if (bus0.AD_CS === 1'b0) begin
                    cs_low_len++;
                    if (bus0.AD_SCLK !== prev_sclk) begin
                        check("sclk_phase_width", run_len, CLK_DIV);
                        if (bus0.AD_SCLK === 1'b1) rise_cnt++;
                        run_len = 1;
                    end else begin
                        run_len++;
                    end
                end else begin
                    cs_high_len++;
                    if (bus0.AD_SCLK !== 1'b0) check("sclk_idle_while_cs_high", 32'(bus0.AD_SCLK), 32'h0);
                end
            end
            prev_cs   = bus0.AD_CS;
            prev_sclk = bus0.AD_SCLK;
        end
    end

    task automatic start0(input logic [31:0] word, input logic [15:0] data);
        exp_t e;
        model_q.push_back(word);
        bus0.TR = 1'b1;
        e.data = data;
        e.at   = cyc + 1 + LAT;
        exp_q.push_back(e);
        @(negedge CLK);
        bus0.TR = 1'b0;
    endtask

    task automatic wait_valid(input int target, input int budget);
        int n = 0;
        while (valid_cnt < target && n < budget) begin
            @(negedge CLK);
            n++;
        end
        if (valid_cnt < target) check("valid_timeout", valid_cnt, target);
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (bus0.BUSY !== 1'b0 && n < budget) begin
            @(negedge CLK);
            n++;
        end
        if (bus0.BUSY !== 1'b0) check("busy_timeout", 32'(bus0.BUSY), 32'h0);
    endtask

    initial begin : stimulus
        int vc;
        int k;
        int n;
        int rises;
        int last_rise;
        logic p;
        bit got;

        bus0.TR = 1'b0;
        bus1.TR = 1'b0;
        #1 RESET = 1'b1;
        repeat (3) @(negedge CLK);

        // Reset state of both instances.
        check("reset_cs", 32'(bus0.AD_CS), 32'h1);
        check("reset_sclk", 32'(bus0.AD_SCLK), 32'h0);
        check("reset_data", 32'(bus0.DATA), 32'h0);
        check("reset_valid", 32'(bus0.VALID), 32'h0);
        check("reset_busy", 32'(bus0.BUSY), 32'h0);
        check("reset_cs_fast", 32'(bus1.AD_CS), 32'h1);
        RESET = 1'b0;
        phase_en = 1'b1;
        @(negedge CLK);

        // Single transfer with lead bits 101010 and sample A5C3.
        vc = valid_cnt;
        start0({10'b0, 6'b101010, 16'hA5C3}, 16'hA5C3);
        wait_valid(vc + 1, LAT + 20);
        wait_idle(40);
        check("busy_fall_after_valid", cyc - last_valid_cyc, CS_HIGH + 1);
        check("sclk_rises", rise_cnt, N);
        check("cs_low_cycles", last_cs_low, LAT);
        repeat (5) @(negedge CLK);
        check("data_hold", 32'(bus0.DATA), 32'hA5C3);

        // TR held high: three back-to-back transfers.
        vc = valid_cnt;
        model_q.push_back({10'b0, 6'b111111, 16'h0000});
        model_q.push_back({10'b0, 6'b000000, 16'hFFFF});
        model_q.push_back({10'b0, 6'b010101, 16'h8001});
        bus0.TR = 1'b1;
        k = cyc + 1;
        for (int j = 0; j < 3; j++) begin
            exp_t e;
            e.data = (j == 0) ? 16'h0000 : (j == 1) ? 16'hFFFF : 16'h8001;
            e.at   = k + j * PERIOD + LAT;
            exp_q.push_back(e);
        end
        for (int j = 1; j <= 3; j++) begin
            wait_valid(vc + j, PERIOD + 20);
            if (j > 1) check("cs_high_gap", last_cs_gap, CS_HIGH + 1);
        end
        bus0.TR = 1'b0;
        wait_idle(40);
        check("sclk_rises_b2b", rise_cnt, N);

        // Retrigger 50 cycles into a transfer is ignored.
        repeat (3) @(negedge CLK);
        vc = valid_cnt;
        start0({10'b0, 6'b110011, 16'h3C96}, 16'h3C96);
        repeat (49) @(negedge CLK);
        bus0.TR = 1'b1;
        @(negedge CLK);
        bus0.TR = 1'b0;
        wait_valid(vc + 1, LAT + 20);
        wait_idle(40);
        check("sclk_rises_retrig", rise_cnt, N);
        repeat (200) @(negedge CLK);
        check("single_valid_retrig", valid_cnt, vc + 1);
        check("busy_after_retrig", 32'(bus0.BUSY), 32'h0);

        // Asynchronous reset at bit 10, then a normal transfer.
        vc = valid_cnt;
        start0({10'b0, 6'b000111, 16'hBEEF}, 16'hBEEF);
        n = 0;
        while (rise_cnt < 11 && n < LAT) begin
            @(negedge CLK);
            n++;
        end
        check("reached_bit10", rise_cnt, 11);
        @(posedge CLK);
        #3;
        RESET = 1'b1;
        phase_en = 1'b0;
        #1;
        check("midreset_cs", 32'(bus0.AD_CS), 32'h1);
        check("midreset_sclk", 32'(bus0.AD_SCLK), 32'h0);
        check("midreset_data", 32'(bus0.DATA), 32'h0);
        check("midreset_busy", 32'(bus0.BUSY), 32'h0);
        exp_q.delete();
        repeat (3) @(negedge CLK);
        RESET = 1'b0;
        repeat (2) @(negedge CLK);
        check("no_valid_after_reset", valid_cnt, vc);
        phase_en = 1'b1;
        @(negedge CLK);
        start0({10'b0, 6'b111000, 16'h1234}, 16'h1234);
        wait_valid(vc + 1, LAT + 20);
        wait_idle(40);
        check("sclk_rises_after_reset", rise_cnt, N);

        // Fast instance: CLK_DIV=1, no lead bits, sample 5A5A.
        model1_q.push_back(32'h5A5A);
        bus1.TR = 1'b1;
        k = cyc + 1;
        @(negedge CLK);
        bus1.TR = 1'b0;
        n = 0;
        rises = 0;
        last_rise = 0;
        p = bus1.AD_SCLK;
        got = 1'b0;
        while (!got && n < 100) begin
            if (bus1.AD_SCLK === 1'b1 && p === 1'b0) begin
                if (rises > 0) check("fast_sclk_period", cyc - last_rise, 2);
                last_rise = cyc;
                rises++;
            end
            p = bus1.AD_SCLK;
            if (bus1.VALID === 1'b1) begin
                got = 1'b1;
                check("fast_latency", cyc - k, 32);
                check("fast_data", 32'(bus1.DATA), 32'h5A5A);
            end else begin
                @(negedge CLK);
                n++;
            end
        end
        if (!got) check("fast_valid_timeout", 32'(got), 32'h1);
        check("fast_sclk_rises", rises, N1);

        repeat (20) @(negedge CLK);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
